// File: rtl/fcl_pxl_loader.sv
// rtl/fcl_pxl_loader.sv - pooled conv1 activation packer feeding the first FC layer
//
// Purpose: quantises each signed pooled activation to an unsigned pixel
// (ReLU, right shift by QSHIFT, saturate to PXL_WIDTH bits). Packs
// NUM_PIXELS pixels per filter into a registered buffer and holds it with
// fcl_wake_o high until the FCL side pulses fcl_restart_i.
//
// Ports:
//   fcl_pxl_loader_clk    clock, rising edge
//   fcl_pxl_loader_rst_b  asynchronous active-low reset
//   pool_valid_i          input beat valid
//   pool_sof_i            first beat of a frame, qualified by pool_valid_i
//   pool_data_i           NUM_FILT signed activations, index f = filter f
//   fcl_restart_i         single-cycle release of a full buffer
//   fcl_pixel_data_o      packed pixel buffer [filter][pixel]
//   fcl_wake_o            buffer complete and stable
//   pxl_cnt_o             next write index
//   overflow_o            sticky, a beat was dropped while full
module fcl_pxl_loader #(
   parameter int NUM_FILT     = 6,
   parameter int NUM_PIXELS   = 100,
   parameter int PXL_WIDTH    = 8,
   parameter int OPERAND_WDTH = 22,
   parameter int QSHIFT       = 8,
   parameter int CNT_WIDTH    = 7
) (
   input  logic                                                  fcl_pxl_loader_clk,
   input  logic                                                  fcl_pxl_loader_rst_b,
   input  logic                                                  pool_valid_i,
   input  logic                                                  pool_sof_i,
   input  logic [NUM_FILT-1:0][OPERAND_WDTH-1:0]                 pool_data_i,
   input  logic                                                  fcl_restart_i,
   output logic [NUM_FILT-1:0][NUM_PIXELS-1:0][PXL_WIDTH-1:0]    fcl_pixel_data_o,
   output logic                                                  fcl_wake_o,
   output logic [CNT_WIDTH-1:0]                                  pxl_cnt_o,
   output logic                                                  overflow_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_FULL = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_PIXELS - 1);

   state_t                                               state_q, state_d;
   logic [CNT_WIDTH-1:0]                                 cnt_q, cnt_d, wr_idx;
   logic                                                 ovf_q, ovf_d, wr_en;
   logic [NUM_FILT-1:0][OPERAND_WDTH-1:0]                shifted;
   logic [NUM_FILT-1:0][PXL_WIDTH-1:0]                   pix;
   logic [NUM_FILT-1:0][NUM_PIXELS-1:0][PXL_WIDTH-1:0]   buf_q;

   // Quantiser. The sign bit is tested before shifting, so the shift only
   // ever sees non-negative values and a logical shift is exact.
   always_comb begin
      shifted = '0;
      pix     = '0;
      for (int f = 0; f < NUM_FILT; f++) begin
         shifted[f] = pool_data_i[f] >> QSHIFT;
         if (pool_data_i[f][OPERAND_WDTH-1])
            pix[f] = '0;
         else if (|shifted[f][OPERAND_WDTH-1:PXL_WIDTH])
            pix[f] = '1;
         else
            pix[f] = shifted[f][PXL_WIDTH-1:0];
      end
   end

   always_ff @(posedge fcl_pxl_loader_clk or negedge fcl_pxl_loader_rst_b) begin
      if (!fcl_pxl_loader_rst_b) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state logic. Every accepted beat (IDLE sof or any FILL beat)
   // funnels through wr_en so counter and FULL detection live in one place.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      wr_en   = 1'b0;
      wr_idx  = '0;
      case (state_q)
         ST_IDLE: begin
            if (pool_valid_i && pool_sof_i) begin
               wr_en  = 1'b1;
               wr_idx = '0;
            end
         end
         ST_FILL: begin
            if (pool_valid_i) begin
               wr_en  = 1'b1;
               wr_idx = pool_sof_i ? '0 : cnt_q;
            end
         end
         ST_FULL: begin
            // Restart takes priority over a coincident beat: the beat is
            // dropped without marking overflow.
            if (fcl_restart_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end else if (pool_valid_i) begin
               ovf_d   = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (wr_en) begin
         cnt_d   = wr_idx + CNT_WIDTH'(1);
         state_d = (wr_idx == LAST_IDX) ? ST_FULL : ST_FILL;
      end
   end

   always_ff @(posedge fcl_pxl_loader_clk or negedge fcl_pxl_loader_rst_b) begin
      if (!fcl_pxl_loader_rst_b) begin
         buf_q <= '0;
      end else if (wr_en) begin
         for (int f = 0; f < NUM_FILT; f++)
            buf_q[f][wr_idx] <= pix[f];
      end
   end

   assign fcl_pixel_data_o = buf_q;
   assign fcl_wake_o       = (state_q == ST_FULL);
   assign pxl_cnt_o        = cnt_q;
   assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_fcl_pxl_loader.sv
// tb/tb_fcl_pxl_loader.sv - self-checking bench for fcl_pxl_loader
module tb_fcl_pxl_loader;

   localparam int NF = 6;
   localparam int NP = 100;
   localparam int PW = 8;
   localparam int OW = 22;
   localparam int CW = 7;

   logic                             clk = 1'b0;
   logic                             rst_n = 1'b0;
   logic                             valid = 1'b0;
   logic                             sof = 1'b0;
   logic                             restart = 1'b0;
   logic [NF-1:0][OW-1:0]            data = '0;
   logic [NF-1:0][NP-1:0][PW-1:0]    pix_o;
   logic                             wake_o;
   logic [CW-1:0]                    cnt_o;
   logic                             ovf_o;

   int vectors = 0;
   int errors  = 0;

   // Reference state: pixel array, number of pixels written in the current
   // frame (0 = not in a frame), buffer-held flag, sticky overflow.
   int m_pix [NF][NP];
   int m_cnt;
   bit m_full;
   bit m_ovf;

   fcl_pxl_loader dut (
      .fcl_pxl_loader_clk   (clk),
      .fcl_pxl_loader_rst_b (rst_n),
      .pool_valid_i         (valid),
      .pool_sof_i           (sof),
      .pool_data_i          (data),
      .fcl_restart_i        (restart),
      .fcl_pixel_data_o     (pix_o),
      .fcl_wake_o           (wake_o),
      .pxl_cnt_o            (cnt_o),
      .overflow_o           (ovf_o)
   );

   always #5 clk = ~clk;

   function automatic int q_ref(input logic [OW-1:0] raw);
      int a;
      a = $signed(raw);
      if (a < 0) return 0;
      a = a / 256;
      return (a > 255) ? 255 : a;
   endfunction

   function automatic logic [OW-1:0] rand_act();
      case ($urandom_range(0, 3))
         0:       return OW'($urandom);
         1:       return OW'($urandom_range(0, 65535));
         2:       return OW'(-$urandom_range(1, 5000));
         default: return OW'($urandom_range(0, 20'h1FFFF));
      endcase
   endfunction

   task automatic model_reset();
      for (int f = 0; f < NF; f++)
         for (int n = 0; n < NP; n++)
            m_pix[f][n] = 0;
      m_cnt  = 0;
      m_full = 0;
      m_ovf  = 0;
   endtask

   // Applies the frame rules to whatever is on the inputs at a rising edge.
   task automatic model_edge();
      int idx;
      if (m_full) begin
         if (restart) begin
            m_full = 0;
            m_cnt  = 0;
            m_ovf  = 0;
         end else if (valid) begin
            m_ovf = 1;
         end
      end else if (valid && (sof || m_cnt != 0)) begin
         idx = sof ? 0 : m_cnt;
         for (int f = 0; f < NF; f++)
            m_pix[f][idx] = q_ref(data[f]);
         m_cnt = idx + 1;
         if (m_cnt == NP) m_full = 1;
      end
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int bf;
      int bn;
      bf = -1;
      bn = 0;
      for (int f = 0; f < NF; f++)
         for (int n = 0; n < NP; n++)
            if (bf < 0 && pix_o[f][n] !== PW'(m_pix[f][n])) begin
               bf = f;
               bn = n;
            end
      vectors++;
      assert (bf < 0) else begin
         errors++;
         $error("FAIL %s buffer[%0d][%0d]: observed %0h expected %0h",
                tag, bf, bn, pix_o[bf][bn], m_pix[bf][bn]);
      end
      check_val({tag, " wake"}, 32'(wake_o), 32'(m_full));
      check_val({tag, " cnt"},  32'(cnt_o),  32'(m_cnt));
      check_val({tag, " ovf"},  32'(ovf_o),  32'(m_ovf));
   endtask

   // One clock: inputs driven at the falling edge, model advanced at the
   // rising edge, outputs checked at the next falling edge.
   task automatic cyc(input logic v, input logic s, input logic r,
                      input logic [NF-1:0][OW-1:0] d, input string tag);
      valid   = v;
      sof     = s;
      restart = r;
      data    = d;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic rand_beat(input logic s, input string tag);
      logic [NF-1:0][OW-1:0] d;
      for (int f = 0; f < NF; f++) d[f] = rand_act();
      cyc(1'b1, s, 1'b0, d, tag);
   endtask

   initial begin
      logic [NF-1:0][OW-1:0] d;

      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Ramp frame: beat n, filter f carries (n+f)<<8.
      for (int n = 0; n < NP; n++) begin
         for (int f = 0; f < NF; f++) d[f] = OW'((n + f) << 8);
         cyc(1'b1, n == 0, 1'b0, d, "ramp");
      end
      check_val("ramp wake", 32'(wake_o), 32'd1);
      check_val("ramp cnt", 32'(cnt_o), 32'd100);
      check_val("ramp pix[5][99]", 32'(pix_o[5][99]), 32'd104);
      check_val("ramp pix[0][0]", 32'(pix_o[0][0]), 32'd0);

      // Overflow while full, then release.
      for (int i = 0; i < 3; i++) rand_beat(i == 1, "overflow");
      check_val("overflow set", 32'(ovf_o), 32'd1);
      cyc(1'b0, 1'b0, 1'b1, '0, "restart");
      check_val("restart wake", 32'(wake_o), 32'd0);
      check_val("restart cnt", 32'(cnt_o), 32'd0);
      check_val("restart ovf", 32'(ovf_o), 32'd0);

      // Quantisation corners on index 0.
      d[0] = OW'(-5);
      d[1] = 22'h0000FF;
      d[2] = 22'h0001FF;
      d[3] = 22'h00FFFF;
      d[4] = 22'h1FFFFF;
      d[5] = 22'h200000;
      cyc(1'b1, 1'b1, 1'b0, d, "quant");
      check_val("q neg", 32'(pix_o[0][0]), 32'd0);
      check_val("q 0xff", 32'(pix_o[1][0]), 32'd0);
      check_val("q 0x1ff", 32'(pix_o[2][0]), 32'd1);
      check_val("q 0xffff", 32'(pix_o[3][0]), 32'd255);
      check_val("q sat", 32'(pix_o[4][0]), 32'd255);
      check_val("q minneg", 32'(pix_o[5][0]), 32'd0);

      // Mid-frame sof after 40 beats.
      for (int i = 1; i < 40; i++) rand_beat(1'b0, "pre-sof");
      for (int f = 0; f < NF; f++) d[f] = 22'h007700;
      cyc(1'b1, 1'b1, 1'b0, d, "midsof");
      check_val("midsof pix", 32'(pix_o[2][0]), 32'h77);
      check_val("midsof cnt", 32'(cnt_o), 32'd1);
      for (int i = 0; i < 98; i++) rand_beat(1'b0, "post-sof");
      check_val("post-sof not full", 32'(wake_o), 32'd0);
      rand_beat(1'b0, "post-sof last");
      check_val("post-sof full", 32'(wake_o), 32'd1);

      // Beat to set overflow, then restart and sof beat in the same cycle.
      rand_beat(1'b0, "ovf again");
      for (int f = 0; f < NF; f++) d[f] = rand_act();
      cyc(1'b1, 1'b1, 1'b1, d, "restart+beat");
      check_val("r+b ovf", 32'(ovf_o), 32'd0);
      check_val("r+b cnt", 32'(cnt_o), 32'd0);

      // Idle beats without sof, restart in idle.
      for (int i = 0; i < 5; i++) rand_beat(1'b0, "idle beat");
      cyc(1'b0, 1'b0, 1'b1, '0, "idle restart");

      // Asynchronous reset at beat 50.
      for (int i = 0; i < 50; i++) rand_beat(i == 0, "pre-reset");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NP; i++) rand_beat(i == 0, "after reset");
      check_val("after reset full", 32'(wake_o), 32'd1);

      // Random traffic: gaps, stray sofs, random restarts.
      for (int i = 0; i < 800; i++) begin
         for (int f = 0; f < NF; f++) d[f] = rand_act();
         cyc($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3,
             $urandom_range(0, 99) < 4, d, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
